// File: rtl/sha256_sched_pkg.sv
// Shared types and constants for the SHA-256 nonce scheduler.
//   state_t       : scheduler FSM states
//   SHA256_IV     : FIPS 180-4 initial hash value {H0..H7}
//   PAD_WORD      : leading '1' padding bit placed in a 32-bit word
//   LEN_HDR/LEN_DIGEST : message length fields for the header and digest hashes
//   is_core_state : true for states that own an outstanding core operation
package sha256_sched_pkg;

  localparam int NONCE_W = 32;
  localparam int HDR_W   = 640;
  localparam int BLK_W   = 512;
  localparam int DIG_W   = 256;
  // Header bits that land in block 2 ahead of the nonce (header[127:32]).
  localparam int TAIL_W  = HDR_W - BLK_W - NONCE_W;

  localparam logic [DIG_W-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
  localparam logic [63:0] LEN_HDR    = 64'd640;
  localparam logic [63:0] LEN_DIGEST = 64'd256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLK1,
    ST_BLK2,
    ST_HASH2,
    ST_CHECK,
    ST_FOUND,
    ST_DONE,
    ST_DRAIN
  } state_t;

  function automatic logic is_core_state(input state_t s);
    return (s == ST_BLK1) || (s == ST_BLK2) || (s == ST_HASH2);
  endfunction

endpackage

// File: rtl/sha256_nonce_scheduler_if.sv
// Host-side bus of the nonce scheduler: job offer, abort, hit report and status.
//   master : job source / result consumer (drives job_*, nonce_*, abort, found_ready)
//   slave  : the scheduler (drives job_ready, found_*, exhausted, busy)
interface sha256_nonce_scheduler_if;
  import sha256_sched_pkg::*;

  logic               job_valid;
  logic               job_ready;
  logic [HDR_W-1:0]   job_header;
  logic [DIG_W-1:0]   job_target;
  logic [NONCE_W-1:0] nonce_start;
  logic [NONCE_W-1:0] nonce_end;
  logic               abort;
  logic               found_valid;
  logic               found_ready;
  logic [NONCE_W-1:0] found_nonce;
  logic [DIG_W-1:0]   found_hash;
  logic               exhausted;
  logic               busy;

  modport master (
    output job_valid, job_header, job_target, nonce_start, nonce_end, abort, found_ready,
    input  job_ready, found_valid, found_nonce, found_hash, exhausted, busy
  );

  modport slave (
    input  job_valid, job_header, job_target, nonce_start, nonce_end, abort, found_ready,
    output job_ready, found_valid, found_nonce, found_hash, exhausted, busy
  );

endinterface

// File: rtl/sha256_block_pad.sv
// Combinational construction of the padded SHA-256 blocks that carry variable data.
//   header_tail : header[127:32]
//   nonce       : current nonce (header[31:0] of the hashed message)
//   digest      : first-pass digest, hashed again in the second SHA-256
//   blk2_block  : second block of the 640-bit header message
//   hash2_block : single block of the 256-bit digest message
module sha256_block_pad
  import sha256_sched_pkg::*;
(
  input  logic [TAIL_W-1:0]  header_tail,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [DIG_W-1:0]   digest,
  output logic [BLK_W-1:0]   blk2_block,
  output logic [BLK_W-1:0]   hash2_block
);

  // Zero fill sizes bring each block to exactly 512 bits:
  // 128 data + 32 pad + 288 zero + 64 length, and 256 data + 32 pad + 160 zero + 64 length.
  assign blk2_block  = {header_tail, nonce, PAD_WORD, 288'b0, LEN_HDR};
  assign hash2_block = {digest, PAD_WORD, 160'b0, LEN_DIGEST};

endmodule

// File: rtl/sha256_nonce_scheduler.sv
// Proof-of-work nonce scheduler driving one shared SHA-256 compression core.
// Per nonce: block 1 of the header (IV), block 2 with the nonce (midstate),
// then SHA-256 of that digest (IV); the final digest is compared to the target.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   host         : sha256_nonce_scheduler_if.slave (job offer, abort, hit report, status)
//   core_start   : one-cycle start pulse; core_block/core_iv valid in that cycle
//   core_block   : 512-bit message block
//   core_iv      : chaining input (SHA-256 IV or block-1 midstate)
//   core_done    : one-cycle completion pulse; core_hash valid in that cycle
//   core_hash    : core digest {a..h}
// Configuration macro SHA_MIDSTATE_CACHE_EN: when defined, block 1 runs once per job
// and its midstate is kept for every nonce; otherwise each nonce reruns block 1.
module sha256_nonce_scheduler
  import sha256_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  sha256_nonce_scheduler_if.slave host,
  output logic                 core_start,
  output logic [BLK_W-1:0]     core_block,
  output logic [DIG_W-1:0]     core_iv,
  input  logic                 core_done,
  input  logic [DIG_W-1:0]     core_hash
);

`ifdef SHA_MIDSTATE_CACHE_EN
  localparam state_t LOOP_STATE = ST_BLK2;
`else
  localparam state_t LOOP_STATE = ST_BLK1;
`endif

  state_t                    state_reg, state_next;
  logic [HDR_W-NONCE_W-1:0]  header_reg;   // header[639:32]; the nonce field is never stored
  logic [DIG_W-1:0]          target_reg;
  logic [NONCE_W-1:0]        nonce_reg;
  logic [NONCE_W-1:0]        nonce_end_reg;
  logic [DIG_W-1:0]          digest_reg;   // last core result of the current op chain
  logic                      core_start_reg;
  logic                      nonce_advance;
  logic                      hit;
  logic                      last_nonce;
  logic [DIG_W-1:0]          midstate;
  logic [BLK_W-1:0]          blk2_block;
  logic [BLK_W-1:0]          hash2_block;
  logic                      unused_nonce_field;

  assign unused_nonce_field = ^host.job_header[NONCE_W-1:0];

`ifdef SHA_MIDSTATE_CACHE_EN
  logic [DIG_W-1:0] midstate_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      midstate_reg <= '0;
    end else if (core_done && state_reg == ST_BLK1) begin
      midstate_reg <= core_hash;
    end
  end

  assign midstate = midstate_reg;
`else
  // Without the cache the block-1 result is still in digest_reg when block 2 starts.
  assign midstate = digest_reg;
`endif

  assign hit        = (digest_reg <= target_reg);
  assign last_nonce = (nonce_reg == nonce_end_reg);

  sha256_block_pad u_pad (
    .header_tail (header_reg[TAIL_W-1:0]),
    .nonce       (nonce_reg),
    .digest      (digest_reg),
    .blk2_block  (blk2_block),
    .hash2_block (hash2_block)
  );

  always_comb begin
    state_next    = state_reg;
    nonce_advance = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (host.job_valid) state_next = ST_BLK1;
      end
      ST_BLK1, ST_BLK2, ST_HASH2: begin
        // An op is always outstanding here; abort waits it out unless it ends now.
        if (host.abort) begin
          state_next = core_done ? ST_IDLE : ST_DRAIN;
        end else if (core_done) begin
          case (state_reg)
            ST_BLK1: state_next = ST_BLK2;
            ST_BLK2: state_next = ST_HASH2;
            default: state_next = ST_CHECK;
          endcase
        end
      end
      ST_CHECK: begin
        if (host.abort) begin
          state_next = ST_IDLE;
        end else if (hit) begin
          state_next = ST_FOUND;
        end else if (last_nonce) begin
          state_next = ST_DONE;
        end else begin
          nonce_advance = 1'b1;
          state_next    = LOOP_STATE;
        end
      end
      ST_FOUND: begin
        if (host.abort) begin
          state_next = ST_IDLE;
        end else if (host.found_ready) begin
          if (last_nonce) begin
            state_next = ST_DONE;
          end else begin
            nonce_advance = 1'b1;
            state_next    = LOOP_STATE;
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_DRAIN: if (core_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      header_reg     <= '0;
      target_reg     <= '0;
      nonce_reg      <= '0;
      nonce_end_reg  <= '0;
      digest_reg     <= '0;
      core_start_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      // Every core state is entered from a different state, so this fires once per entry.
      core_start_reg <= is_core_state(state_next) && (state_next != state_reg);
      if (state_reg == ST_IDLE && host.job_valid) begin
        header_reg    <= host.job_header[HDR_W-1:NONCE_W];
        target_reg    <= host.job_target;
        nonce_reg     <= host.nonce_start;
        nonce_end_reg <= host.nonce_end;
      end else if (nonce_advance) begin
        nonce_reg <= nonce_reg + NONCE_W'(1);
      end
      if (core_done && is_core_state(state_reg)) begin
        digest_reg <= core_hash;
      end
    end
  end

  always_comb begin
    core_block = '0;
    core_iv    = SHA256_IV;
    case (state_reg)
      ST_BLK1:  core_block = header_reg[HDR_W-NONCE_W-1 -: BLK_W];
      ST_BLK2: begin
        core_block = blk2_block;
        core_iv    = midstate;
      end
      ST_HASH2: core_block = hash2_block;
      default:  core_block = '0;
    endcase
  end

  assign core_start       = core_start_reg;
  assign host.job_ready   = (state_reg == ST_IDLE);
  assign host.busy        = (state_reg != ST_IDLE);
  assign host.found_valid = (state_reg == ST_FOUND);
  assign host.found_nonce = nonce_reg;
  assign host.found_hash  = digest_reg;
  assign host.exhausted   = (state_reg == ST_DONE);

endmodule
